// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU response receive path.
package alu_pkg;

  typedef enum logic {DATA = 1'b0, CMD = 1'b1} byte_type_t;

  typedef enum logic [1:0] {IDLE, BITS, WAIT_HIGH} rx_state_t;

  // start + type + 8 data + stop
  localparam int BYTE_FRAME_BITS = 11;

  // x^3 + x + 1 with the x^3 term implied
  localparam logic [2:0] CRC3_POLY = 3'b011;

endpackage

// File: rtl/alu_byte_rx.sv
// Serial byte receiver: input synchroniser plus byte-frame FSM.
// Emits one-cycle byte_valid (good stop bit) or stop_err (stop bit low) pulses.
module alu_byte_rx
  import alu_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sout,
  output logic       byte_valid,
  output byte_type_t byte_type,
  output logic [7:0] byte_data,
  output logic       stop_err
);

  // counter value while the stop bit is on the synchronised line
  localparam logic [3:0] LAST_BIT = 4'(BYTE_FRAME_BITS - 2);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  rx_state_t              state, state_nxt;
  logic [3:0]             cnt;
  logic [8:0]             sr;

  assign s = sync[SYNC_STAGES-1];

  // input flop chain; filled with the idle level on reset
  always_ff @(posedge clk) begin
    if (!rst_n) sync <= '1;
    else        sync <= SYNC_STAGES'({sync, sout});
  end

  // byte FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // byte FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (!s) state_nxt = BITS;
      BITS:      if (cnt == LAST_BIT) state_nxt = s ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (s) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // bit counter, {type,data} shifter and registered byte pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      sr         <= '0;
      byte_valid <= 1'b0;
      stop_err   <= 1'b0;
      byte_type  <= DATA;
      byte_data  <= '0;
    end else begin
      byte_valid <= 1'b0;
      stop_err   <= 1'b0;
      if (state == BITS) begin
        if (cnt == LAST_BIT) begin
          cnt <= '0;
          if (s) begin
            byte_valid <= 1'b1;
            byte_type  <= byte_type_t'(sr[8]);
            byte_data  <= sr[7:0];
          end else begin
            stop_err <= 1'b1;
          end
        end else begin
          sr  <= {sr[7:0], s};
          cnt <= cnt + 4'd1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/alu_resp_deserializer.sv
// ALU response deserializer: byte receiver plus packet decoder.
// Result packet: N_DATA_BYTES DATA bytes (MSB first) + CMD {0, flags, crc3}.
// Error packet : single CMD {1, err_flags, parity}.
// Build option ALU_RESP_CRC_CHECK_EN: when defined, crc_ok checks the received
// crc3; otherwise no CRC logic is built and crc_ok is 1 on every result.
module alu_resp_deserializer
  import alu_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int N_DATA_BYTES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sout,
  output logic        resp_valid,
  output logic [31:0] result,
  output logic [3:0]  flags,
  output logic        crc_ok,
  output logic        err_valid,
  output logic [5:0]  err_flags,
  output logic        parity_ok,
  output logic        frame_err
);

  localparam int             DW    = $clog2(N_DATA_BYTES + 1);
  localparam logic [DW-1:0]  DFULL = DW'(N_DATA_BYTES);

  logic        byte_valid;
  byte_type_t  byte_type;
  logic [7:0]  byte_data;
  logic        stop_err;
  logic [31:0] result_sr;
  logic [DW-1:0] dcnt;
  logic        crc_good;

  alu_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .sout       (sout),
    .byte_valid (byte_valid),
    .byte_type  (byte_type),
    .byte_data  (byte_data),
    .stop_err   (stop_err)
  );

`ifdef ALU_RESP_CRC_CHECK_EN
  // bit-serial CRC3, MSB first, init 0
  function automatic logic [2:0] crc3(input logic [36:0] msg);
    logic [2:0] c;
    c = '0;
    for (int i = 36; i >= 0; i--)
      c = {c[1:0], 1'b0} ^ ({3{c[2] ^ msg[i]}} & CRC3_POLY);
    return c;
  endfunction

  assign crc_good = (crc3({result_sr, 1'b0, byte_data[6:3]}) == byte_data[2:0]);
`else
  assign crc_good = 1'b1;
`endif

  // packet decoder: byte stream -> result / error / frame_err pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dcnt       <= '0;
      result_sr  <= '0;
      resp_valid <= 1'b0;
      result     <= '0;
      flags      <= '0;
      crc_ok     <= 1'b0;
      err_valid  <= 1'b0;
      err_flags  <= '0;
      parity_ok  <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      err_valid  <= 1'b0;
      frame_err  <= 1'b0;
      if (stop_err) begin
        frame_err <= 1'b1;
        dcnt      <= '0;
      end else if (byte_valid) begin
        if (byte_type == DATA) begin
          if (dcnt < DFULL) begin
            result_sr <= {result_sr[23:0], byte_data};
            dcnt      <= dcnt + 1'b1;
          end else begin
            frame_err <= 1'b1;
            dcnt      <= '0;
          end
        end else if (dcnt == DFULL && !byte_data[7]) begin
          result     <= result_sr;
          flags      <= byte_data[6:3];
          crc_ok     <= crc_good;
          resp_valid <= 1'b1;
          dcnt       <= '0;
        end else if (dcnt == '0 && byte_data[7]) begin
          err_flags <= byte_data[6:1];
          parity_ok <= ~^{1'b1, byte_data[6:0]};
          err_valid <= 1'b1;
        end else begin
          frame_err <= 1'b1;
          dcnt      <= '0;
        end
      end
    end
  end

endmodule
